// File: rtl/quadrature_tracker_pkg.sv
// Shared types for the quadrature tracker: resolution modes, tracker states,
// quadrant encoding and the per-mode step filter.
package quadrature_tracker_pkg;

  typedef enum logic [1:0] {
    MODE_X1     = 2'd0,
    MODE_X2     = 2'd1,
    MODE_X4     = 2'd2,
    MODE_X4_ALT = 2'd3
  } mode_t;

  typedef enum logic {
    ACQUIRE = 1'b0,
    TRACK   = 1'b1
  } state_t;

  typedef logic [1:0] quadrant_t;

  // Gray-ordered quadrant: ab=00->0, 01->1, 11->2, 10->3
  function automatic quadrant_t quadrant(input logic a, input logic b);
    quadrant_t q;
    q = {a, a ^ b};
    return q;
  endfunction

  function automatic logic step_counts(input mode_t mode, input quadrant_t q_old,
                                       input quadrant_t q_new);
    logic ok;
    case (mode)
      MODE_X1: ok = ((q_old == 2'd3) && (q_new == 2'd0)) ||
                    ((q_old == 2'd0) && (q_new == 2'd3));
      MODE_X2: ok = (q_old[1] != q_new[1]);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/quadrature_tracker_if.sv
// AXI-Stream pair seen by the tracker: sample input (S_AXIS) and position
// output (M_AXIS). The tracker connects through the slave modport.
interface quadrature_tracker_if #(
  parameter int AXIS_TDATA_WIDTH = 32
);
  logic                        S_AXIS_tvalid;
  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata;
  logic                        S_AXIS_tready;
  logic                        M_AXIS_tvalid;
  logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata;
  logic                        M_AXIS_tready;

  modport master (
    output S_AXIS_tvalid, S_AXIS_tdata, M_AXIS_tready,
    input  S_AXIS_tready, M_AXIS_tvalid, M_AXIS_tdata
  );

  modport slave (
    input  S_AXIS_tvalid, S_AXIS_tdata, M_AXIS_tready,
    output S_AXIS_tready, M_AXIS_tvalid, M_AXIS_tdata
  );
endinterface

// File: rtl/quadrature_tracker_hysteresis_comparator.sv
// Signed hysteresis slicer for one quadrature channel; holds its bit inside the
// band and flags resolved once the first decision has been made.
module quadrature_tracker_hysteresis_comparator #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en,
  input  logic signed [WIDTH-1:0] i_sample,
  input  logic signed [WIDTH-1:0] i_lower,
  input  logic signed [WIDTH-1:0] i_upper,
  output logic                    o_bit,
  output logic                    o_resolved
);

  logic r_bit;
  logic r_resolved;
  logic w_band_ok;

  // An inverted band freezes the channel rather than chattering
  assign w_band_ok = (i_lower <= i_upper);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit      <= 1'b0;
      r_resolved <= 1'b0;
    end else if (i_en && w_band_ok) begin
      if (i_sample > i_upper) begin
        r_bit      <= 1'b1;
        r_resolved <= 1'b1;
      end else if (i_sample < i_lower) begin
        r_bit      <= 1'b0;
        r_resolved <= 1'b1;
      end
    end
  end

  assign o_bit      = r_bit;
  assign o_resolved = r_resolved;

endmodule

// File: rtl/quadrature_tracker.sv
// Two-stage A/B quadrature decoder producing a signed position stream.
// Define QUAD_TRACKER_ERRCNT_EN to build the saturating illegal-jump counter.
module quadrature_tracker
  import quadrature_tracker_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int POSITION_WIDTH   = 32
) (
  input  logic                                 aclk,
  input  logic                                 areset,
  input  logic signed [AXIS_TDATA_WIDTH/2-1:0] FC_lower_threshold,
  input  logic signed [AXIS_TDATA_WIDTH/2-1:0] FC_upper_threshold,
  input  logic [1:0]                           FC_mode,
  input  logic                                 FC_clear,
  quadrature_tracker_if.slave                  axis,
  output logic                                 direction,
  output logic [15:0]                          err_count
);

  localparam int HW = AXIS_TDATA_WIDTH / 2;

  logic                      w_adv;
  logic                      w_s1_en;
  logic                      w_bit_a;
  logic                      w_bit_b;
  logic                      w_res_a;
  logic                      w_res_b;
  logic                      r_s1_valid;
  mode_t                     r_s1_mode;
  logic                      w_decode;
  quadrant_t                 w_q;
  quadrant_t                 w_delta;
  quadrant_t                 r_q_old;
  state_t                    r_state;
  state_t                    w_state_next;
  logic                      w_load_q;
  logic                      w_step_up;
  logic                      w_step_dn;
  logic [POSITION_WIDTH-1:0] r_position;
  logic                      r_direction;
  logic                      r_m_tvalid;

  // Whole pipeline advances together; a held output beat freezes both stages
  assign w_adv              = ~r_m_tvalid | axis.M_AXIS_tready;
  assign axis.S_AXIS_tready = w_adv;
  assign w_s1_en            = w_adv & axis.S_AXIS_tvalid;

  quadrature_tracker_hysteresis_comparator #(.WIDTH(HW)) u_cmp_a (
    .clk        (aclk),
    .rst        (areset),
    .i_en       (w_s1_en),
    .i_sample   (axis.S_AXIS_tdata[HW-1:0]),
    .i_lower    (FC_lower_threshold),
    .i_upper    (FC_upper_threshold),
    .o_bit      (w_bit_a),
    .o_resolved (w_res_a)
  );

  quadrature_tracker_hysteresis_comparator #(.WIDTH(HW)) u_cmp_b (
    .clk        (aclk),
    .rst        (areset),
    .i_en       (w_s1_en),
    .i_sample   (axis.S_AXIS_tdata[2*HW-1:HW]),
    .i_lower    (FC_lower_threshold),
    .i_upper    (FC_upper_threshold),
    .o_bit      (w_bit_b),
    .o_resolved (w_res_b)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= MODE_X1;
    end else if (w_adv) begin
      r_s1_valid <= axis.S_AXIS_tvalid;
      if (axis.S_AXIS_tvalid) begin
        r_s1_mode <= mode_t'(FC_mode);
      end
    end
  end

  assign w_decode = w_adv & r_s1_valid;
  assign w_q      = quadrant(w_bit_a, w_bit_b);
  assign w_delta  = w_q - r_q_old;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= ACQUIRE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load_q     = 1'b0;
    w_step_up    = 1'b0;
    w_step_dn    = 1'b0;
    if (w_decode) begin
      case (r_state)
        ACQUIRE: begin
          if (w_res_a && w_res_b) begin
            w_state_next = TRACK;
            w_load_q     = 1'b1;
          end
        end
        TRACK: begin
          w_load_q = 1'b1;
          if (w_delta == 2'd1) begin
            w_step_up = step_counts(r_s1_mode, r_q_old, w_q);
          end else if (w_delta == 2'd3) begin
            w_step_dn = step_counts(r_s1_mode, r_q_old, w_q);
          end
        end
        default: w_state_next = ACQUIRE;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_q_old     <= 2'd0;
      r_position  <= '0;
      r_direction <= 1'b0;
      r_m_tvalid  <= 1'b0;
    end else if (w_adv) begin
      r_m_tvalid <= r_s1_valid;
      if (w_load_q) begin
        r_q_old <= w_q;
      end
      // Clear wins over a coincident step; tracking state is left untouched
      if (FC_clear) begin
        r_position <= '0;
      end else if (w_step_up) begin
        r_position <= r_position + 1'b1;
      end else if (w_step_dn) begin
        r_position <= r_position - 1'b1;
      end
      if (w_step_up) begin
        r_direction <= 1'b1;
      end else if (w_step_dn) begin
        r_direction <= 1'b0;
      end
    end
  end

  assign axis.M_AXIS_tvalid = r_m_tvalid;
  assign direction          = r_direction;

  generate
    if (POSITION_WIDTH >= AXIS_TDATA_WIDTH) begin : g_trunc
      assign axis.M_AXIS_tdata = r_position[AXIS_TDATA_WIDTH-1:0];
    end else begin : g_sext
      assign axis.M_AXIS_tdata = {{(AXIS_TDATA_WIDTH-POSITION_WIDTH){r_position[POSITION_WIDTH-1]}},
                                  r_position};
    end
  endgenerate

`ifdef QUAD_TRACKER_ERRCNT_EN
  logic        w_illegal;
  logic [15:0] r_err_count;

  assign w_illegal = w_decode && (r_state == TRACK) && (w_delta == 2'd2);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_err_count <= 16'd0;
    end else if (FC_clear) begin
      r_err_count <= 16'd0;
    end else if (w_illegal && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = 16'd0;
`endif

endmodule
